// File: rtl/imem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between the core bus master
// and the UART debug loader, draining core traffic and pulsing a core reset per session.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MEM_DEPTH_WORDS = 4096,
  parameter int unsigned RST_HOLD        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dbg_sess_i,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [3:0]        core_be_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              core_hold_o,
  output logic              core_rst_o,
  output logic [15:0]       dbg_wr_cnt_o,
  output logic              err_o
);

  localparam int unsigned       CntW       = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CntW-1:0]   CntLast    = CntW'(RST_HOLD - 1);
  localparam logic [ADDR_W-1:0] DepthWords = ADDR_W'(MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {
    StCore,
    StDrain,
    StDebug,
    StRelease
  } state_e;

  state_e              state_q, state_d;
  logic                rd_pend_q, rd_pend_d;
  logic                drain_ext_q, drain_ext_d;
  logic [CntW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                hold_q, hold_d;
  logic                crst_q, crst_d;
  logic [15:0]         wr_cnt_q, wr_cnt_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   dbg_word_idx;
  logic                dbg_addr_ok;

  assign dbg_word_idx = {2'b00, dbg_addr_i[ADDR_W-1:2]};
  assign dbg_addr_ok  = (dbg_addr_i[1:0] == 2'b00) && (dbg_word_idx < DepthWords);

  // Grants are suppressed while reset is asserted so no write lands during reset.
  always_comb begin
    core_gnt_o = 1'b0;
    dbg_gnt_o  = 1'b0;
    if (!rst_i) begin
      if (state_q == StCore)  core_gnt_o = core_req_i & ~dbg_sess_i;
      if (state_q == StDebug) dbg_gnt_o  = dbg_req_i & dbg_sess_i;
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'h0;
    if (core_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
      mem_be_o    = core_be_i;
    end else if (dbg_gnt_o) begin
      // A rejected loader write is consumed but never strobes the memory.
      mem_req_o   = dbg_addr_ok;
      mem_we_o    = 1'b1;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
      mem_be_o    = 4'hF;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_ext_d = drain_ext_q;
    rst_cnt_d   = rst_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    err_d       = err_q;
    rd_pend_d   = core_gnt_o & ~core_we_i;
    rdata_d     = rd_pend_q ? mem_rdata_i : rdata_q;

    unique case (state_q)
      StCore: begin
        if (dbg_sess_i) begin
          state_d     = StDrain;
          // A read still returning data when the session starts costs one extra drain cycle.
          drain_ext_d = rd_pend_q;
        end
      end
      StDrain: begin
        if (drain_ext_q || rd_pend_q) begin
          drain_ext_d = 1'b0;
        end else begin
          state_d = StDebug;
        end
      end
      StDebug: begin
        if (!dbg_sess_i) begin
          state_d   = StRelease;
          rst_cnt_d = '0;
        end else if (dbg_gnt_o) begin
          if (dbg_addr_ok) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRelease: begin
        if (rst_cnt_q == CntLast) begin
          rst_cnt_d = '0;
          state_d   = dbg_sess_i ? StDrain : StCore;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: state_d = StCore;
    endcase

    if (state_d == StDrain && state_q != StDrain) begin
      wr_cnt_d = 16'd0;
      err_d    = 1'b0;
    end

    hold_d = (state_d != StCore);
    crst_d = (state_d == StRelease);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StCore;
      rd_pend_q   <= 1'b0;
      drain_ext_q <= 1'b0;
      rst_cnt_q   <= '0;
      rdata_q     <= '0;
      hold_q      <= 1'b0;
      crst_q      <= 1'b0;
      wr_cnt_q    <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      drain_ext_q <= drain_ext_d;
      rst_cnt_q   <= rst_cnt_d;
      rdata_q     <= rdata_d;
      hold_q      <= hold_d;
      crst_q      <= crst_d;
      wr_cnt_q    <= wr_cnt_d;
      err_q       <= err_d;
    end
  end

  assign core_rvalid_o = rd_pend_q;
  assign core_rdata_o  = rd_pend_q ? mem_rdata_i : rdata_q;
  assign core_hold_o   = hold_q;
  assign core_rst_o    = crst_q;
  assign dbg_wr_cnt_o  = wr_cnt_q;
  assign err_o         = err_q;

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction/data memory port between two masters: the core bus master and the UART debug download loader.
- In normal operation the core owns the port. When a debug session is active, the arbiter drains in-flight core traffic, hands the port exclusively to the loader and holds the core. When the session ends, it pulses a core reset so execution restarts from the freshly loaded image.
- Sits between the core/RIB master side and the memory macro.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_DEPTH_WORDS, 4096, number of memory words; debug writes at or beyond this index are rejected
RST_HOLD, 16, cycles core_rst_o is held high after a session ends (min 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
dbg_sess_i  in  1  debug session active (already synchronised by the loader)
dbg_req_i  in  1  loader write request
dbg_addr_i  in  ADDR_W  loader byte address
dbg_wdata_i  in  DATA_W  loader write data
dbg_gnt_o  out  1  loader request accepted this cycle
core_req_i  in  1  core access request
core_we_i  in  1  core write enable
core_addr_i  in  ADDR_W  core byte address
core_wdata_i  in  DATA_W  core write data
core_be_i  in  4  core byte enables
core_gnt_o  out  1  core request accepted this cycle
core_rvalid_o  out  1  core read data valid
core_rdata_o  out  DATA_W  core read data
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory byte address
mem_wdata_o  out  DATA_W  memory write data
mem_be_o  out  4  memory byte enables
mem_rdata_i  in  DATA_W  memory read data (valid 1 cycle after read strobe)
core_hold_o  out  1  stall core pipeline
core_rst_o  out  1  core reset request
dbg_wr_cnt_o  out  16  words written this session
err_o  out  1  sticky: rejected debug write this session

Behaviour:
- FSM states: CORE, DRAIN, DEBUG, RELEASE. Reset: state=CORE, rd_pend=0, core_rvalid_o=0, core_rdata_o=0, core_hold_o=0, core_rst_o=0, dbg_wr_cnt_o=0, err_o=0, rst_cnt=0.
- Grants are combinational in the request cycle.
- mem_* is a combinational mux of the granted master. When nothing is granted: mem_req_o=0 and all other mem_* outputs are 0.
- CORE state:
  - core_gnt_o = core_req_i & !dbg_sess_i.
  - dbg_gnt_o = 0.
  - dbg_sess_i=1 -> DRAIN next cycle. Core is not granted in that cycle.
- rd_pend: set on a granted core read (core_we_i=0), cleared the following cycle. In the cycle after a granted read: core_rvalid_o=1 and core_rdata_o=mem_rdata_i (registered capture). Otherwise core_rvalid_o=0 and core_rdata_o holds its value.
- DRAIN state:
  - No grants; core_hold_o=1.
  - Entry clears dbg_wr_cnt_o and err_o.
  - Next state = DEBUG when rd_pend=0. DRAIN therefore lasts 1 cycle, or 2 if a read was pending.
- DEBUG state:
  - core_hold_o=1; dbg_gnt_o = dbg_req_i & dbg_sess_i. Write only: mem_we_o=1, mem_be_o=4'hF.
  - Rejected write: dbg_addr_i[1:0]!=0, or dbg_addr_i[ADDR_W-1:2] >= MEM_DEPTH_WORDS. It is still granted (consumed) but mem_req_o=0 and err_o<=1.
  - Accepted write: dbg_wr_cnt_o increments, saturating at 16'hFFFF.
  - dbg_sess_i=0 -> RELEASE. A request presented in that same cycle is not granted.
- RELEASE state:
  - No grants; core_hold_o=1, core_rst_o=1, rst_cnt counts 0..RST_HOLD-1.
  - At RST_HOLD-1: next state is DRAIN if dbg_sess_i=1, else CORE. rst_cnt clears.
  - A session that re-asserts mid-RELEASE does not shorten the reset pulse.
- core_hold_o and core_rst_o are registered from the next state, so they change on the same edge as the state.
- dbg_wr_cnt_o and err_o persist after the session until the next DRAIN entry.
- rst_i mid-operation: return to CORE immediately with reset values. In-flight reads are discarded (no rvalid).

Test Plan:
- Core read at 0x40 in CORE, mem_rdata_i=0xDEADBEEF -> core_gnt_o=1, mem_req_o=1, mem_we_o=0 same cycle; core_rvalid_o=1, core_rdata_o=0xDEADBEEF next cycle.
- Core read granted, then dbg_sess_i rises the next cycle -> that read's rvalid still delivered; DRAIN lasts 2 cycles; DEBUG entered; core_hold_o=1; no core grant throughout.
- Session with 3 loader writes to 0x0, 0x4, 0x8 (data 1, 2, 3) -> three mem writes with be=F; dbg_wr_cnt_o=3; err_o=0.
- Loader writes to 0x2 and to MEM_DEPTH_WORDS*4 -> both granted, mem_req_o=0, err_o=1, dbg_wr_cnt_o unchanged.
- dbg_sess_i falls -> core_rst_o high exactly RST_HOLD (16) cycles, then CORE with core_hold_o=0. Session re-asserted at cycle 5 of RELEASE -> still 16 cycles, then DRAIN; err_o and dbg_wr_cnt_o cleared.
- rst_i asserted during DEBUG with dbg_req_i=1 -> next cycle state CORE, all outputs at reset values, no mem_req_o.
